sram_2port_wmask: RTL
=====================

# sram_2port_wmask

Parametrised synchronous SRAM model with one read/write port (port 0, per-byte write mask) and one read-only port (port 1), plus a built-in clear sequencer that zeroes the array after reset. It replaces the single-port 1024x32 model as the instruction/data memory for the core, adding a second read port, byte-granular writes, explicit read-valid flags and a defined reset state.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
- ADDR_WIDTH, 10, address width; RAM_DEPTH = 1 << ADDR_WIDTH words
- INIT_CLEAR, 1, 1 = zero the array after reset; 0 = skip clear, ready immediately
- NUM_WMASKS (localparam), DATA_WIDTH/8, one mask bit per byte

Ports:
- clk0  in  1  single clock; all logic on rising edge
- rst0  in  1  reset, synchronous, active-high
- init_done  out  1  1 when the array accepts requests
- csb0  in  1  port 0 chip select, active low
- web0  in  1  port 0 write enable, active low
- wmask0  in  NUM_WMASKS  port 0 byte write mask, bit i enables din0[8i+7:8i]
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- dout0_valid  out  1  dout0 updated by a read this cycle
- csb1  in  1  port 1 chip select, active low
- addr1  in  ADDR_WIDTH  port 1 read address
- dout1  out  DATA_WIDTH  port 1 read data
- dout1_valid  out  1  dout1 updated by a read this cycle
- collision  out  1  port 1 read hit the address port 0 wrote in the same cycle

## Operation
- States: ST_INIT, ST_READY.
- Reset (rst0=1 at an edge): state <= ST_INIT if INIT_CLEAR else ST_READY; clear counter <= 0; dout0, dout1 <= 0; dout0_valid, dout1_valid, collision <= 0; init_done <= 0 if INIT_CLEAR else 1. rst0 has priority over all requests.
- ST_INIT: each cycle write 0 to mem[cnt], cnt++. On the edge where cnt == RAM_DEPTH-1: write final word, go ST_READY, init_done <= 1. All csb0/csb1 requests ignored (valids stay 0, no writes).
- Reset during ST_INIT restarts the clear from address 0.
- ST_READY, port 0:
  - csb0=0, web0=0: for each i with wmask0[i]=1, mem[addr0] byte i <= din0 byte i; other bytes unchanged. wmask0=0 is a legal no-op. dout0 holds, dout0_valid <= 0.
  - csb0=0, web0=1: dout0 <= mem[addr0], dout0_valid <= 1.
  - csb0=1: dout0 holds, dout0_valid <= 0.
- ST_READY, port 1: csb1=0: dout1 <= mem[addr1], dout1_valid <= 1; else dout1 holds, dout1_valid <= 0.
- Same-cycle port 0 write and port 1 read of same address: read-first — dout1 gets pre-write contents; collision <= 1 for one cycle (even if wmask0=0). Otherwise collision <= 0.
- Both ports reading the same address: both return the same word, no collision.
- Memory contents are not affected by reset when INIT_CLEAR=0.

## Timing
- Read latency 1 cycle: request sampled at edge N, dout/valid visible after edge N, valid high for exactly one cycle per request.
- Write visible to any read sampled at edge N+1 or later.
- Back-to-back reads on every cycle supported on both ports; no stalls in ST_READY.
- Clear sequence: RAM_DEPTH cycles after reset release; init_done rises after edge RAM_DEPTH (counting the first edge with rst0=0 as 1).
- No internal delays (#); outputs change only at clk0 rising edges.

## Structure
- Package sram_pkg: state enum (ST_INIT, ST_READY), default DATA_WIDTH/ADDR_WIDTH constants, byte width constant 8.
- Sub-module sram_init_ctrl: state register, clear counter, init_done; outputs clear-write enable and clear address to the array wrapper.
- Top holds the array, per-byte write loop, read registers, collision compare.

## Test plan
- Reset with INIT_CLEAR=1, then wait: init_done=0 for 1024 cycles then 1; read addr0=0x3FF -> dout0=0x00000000, dout0_valid=1 one cycle later.
- Write addr0=0x010 din0=0xDEADBEEF wmask0=4'b1111, then wmask0=4'b0010 din0=0x0000AA00 -> read returns 0xDEADAAEF.
- Same cycle: port 0 writes 0x12345678 to 0x020 (old 0x0), port 1 reads 0x020 -> dout1=0x00000000, collision=1; next-cycle read -> 0x12345678, collision=0.
- Requests issued during ST_INIT (write 0xFFFFFFFF to 0x005) -> ignored; after init_done, read 0x005 -> 0x00000000, no valid pulses during init.
- Assert rst0 for one cycle at clear count 500 -> counter restarts, init_done rises 1024 cycles after release; dout0/dout1 read 0 and valids 0 during reset.
- INIT_CLEAR=0: init_done=1 the cycle after reset; alternating reads on both ports every cycle -> each valid high one cycle per request, correct data.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and defaults for the dual-port byte-masked SRAM model.
package sram_pkg;
  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int BYTE_W         = 8;
endpackage

// File: rtl/sram_2port_wmask_if.sv
// Request/response bundle for the SRAM: port 0 (rw, byte mask), port 1 (read), status.
interface sram_2port_wmask_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  logic                  init_done;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  collision;

  modport master (
    input  init_done, dout0, dout0_valid, dout1, dout1_valid, collision,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
    output init_done, dout0, dout0_valid, dout1, dout1_valid, collision,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/sram_init_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then opens the array.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  ready_o,
  output logic                  init_done_o
);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= INIT_CLEAR ? ST_INIT : ST_READY;
      cnt_q       <= '0;
      init_done_q <= !INIT_CLEAR;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          // The all-ones count is the last word; its clear write lands on this same edge.
          if (cnt_q == '1) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset must beat both the clear write and any user request on the same edge.
  assign clr_we_o    = (state_q == ST_INIT) && !rst0;
  assign clr_addr_o  = cnt_q;
  assign ready_o     = (state_q == ST_READY) && !rst0;
  assign init_done_o = init_done_q;
endmodule

// File: rtl/sram_2port_wmask.sv
// Dual-port synchronous SRAM: port 0 read/write with byte mask, port 1 read-only, read-first.
module sram_2port_wmask
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk0,
  input  logic              rst0,
  sram_2port_wmask_if.slave bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / BYTE_W;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("sram_2port_wmask: DATA_WIDTH must be a multiple of 8");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready;

  sram_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init (
    .clk0        (clk0),
    .rst0        (rst0),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .ready_o     (ready),
    .init_done_o (bus.init_done)
  );

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] wword_d;
  logic                  wr0, rd0, rd1;

  assign wr0 = ready && !bus.csb0 && !bus.web0;
  assign rd0 = ready && !bus.csb0 &&  bus.web0;
  assign rd1 = ready && !bus.csb1;

  always_comb begin
    wword_d = mem[bus.addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (bus.wmask0[i]) wword_d[i*BYTE_W +: BYTE_W] = bus.din0[i*BYTE_W +: BYTE_W];
    end
  end

  // Array has no reset: contents survive rst0 unless the clear sequencer runs.
  always_ff @(posedge clk0) begin
    if (clr_we)   mem[clr_addr]  <= '0;
    else if (wr0) mem[bus.addr0] <= wword_d;
  end

  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
  logic                  dout0_valid_q, dout1_valid_q, collision_q;

  // Nonblocking array update gives read-first on a port 0 / port 1 address clash.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0_q       <= '0;
      dout1_q       <= '0;
      dout0_valid_q <= 1'b0;
      dout1_valid_q <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      if (rd0) dout0_q <= mem[bus.addr0];
      if (rd1) dout1_q <= mem[bus.addr1];
      dout0_valid_q <= rd0;
      dout1_valid_q <= rd1;
      collision_q   <= wr0 && rd1 && (bus.addr0 == bus.addr1);
    end
  end

  assign bus.dout0       = dout0_q;
  assign bus.dout1       = dout1_q;
  assign bus.dout0_valid = dout0_valid_q;
  assign bus.dout1_valid = dout1_valid_q;
  assign bus.collision   = collision_q;
endmodule
